uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sampler.sv | 64 ++++++
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART link.
//   rx_state_t     : receiver FSM states
//   PAR_EVEN/ODD   : encodings of the PAR_TYP input
//   DEFAULT_DATA_W : default number of data bits per frame
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned DEFAULT_DATA_W = 8;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with a 3-sample majority vote.
//   clk, rst_n  : receiver clock, asynchronous active-low reset
//   rx_in       : synchronised serial line
//   clear       : first low sample of a frame seen; this cycle is edge 0
//   enable      : a bit period is in progress
//   prescale    : latched oversampling ratio
//   sampled_bit : majority of the three mid-bit samples
//   bit_done    : one-cycle pulse on the last edge of a bit
//   edge_cnt    : position within the current bit
module uart_rx_sampler #(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit,
    output logic                  bit_done,
    output logic [PRESCALE_W-1:0] edge_cnt
);

    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last_edge;
    logic [2:0]            samples;

    assign half = prescale >> 1;

    // Out-of-range ratios fall back to a 32-edge bit so no state can stall.
    always_comb begin
        last_edge = prescale - PRESCALE_W'(1);
        if (prescale == '0 || prescale > PRESCALE_W'(32))
            last_edge = PRESCALE_W'(31);
    end

    assign bit_done = enable && (edge_cnt == last_edge);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt    <= '0;
            samples     <= '0;
            sampled_bit <= 1'b1;
        end else begin
            if (clear)
                edge_cnt <= PRESCALE_W'(1);
            else if (enable)
                edge_cnt <= bit_done ? '0 : edge_cnt + PRESCALE_W'(1);
            else
                edge_cnt <= '0;

            if (enable) begin
                if (edge_cnt == half - PRESCALE_W'(1)) samples[0] <= rx_in;
                if (edge_cnt == half)                  samples[1] <= rx_in;
                if (edge_cnt == half + PRESCALE_W'(1)) samples[2] <= rx_in;
                if (edge_cnt == half + PRESCALE_W'(2))
                    sampled_bit <= (samples[0] & samples[1]) |
                                   (samples[0] & samples[2]) |
                                   (samples[1] & samples[2]);
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_W data bits LSB-first, optional parity, one stop.
//   CLK, RST   : oversampled clock, asynchronous active-low reset
//   RX_IN      : synchronised serial line, idle high
//   PAR_EN     : frame carries a parity bit
//   PAR_TYP    : 0 even, 1 odd parity
//   Prescale   : oversampling ratio (8, 16 or 32)
//   P_DATA     : last error-free byte
//   DATA_VALID : one-cycle strobe, P_DATA updated
//   PAR_ERR    : one-cycle strobe, parity mismatch
//   STP_ERR    : one-cycle strobe, stop bit sampled low
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int unsigned BCW = $clog2(DATA_W);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

    rx_state_t state, next_state;

    logic                  par_en_q;
    logic                  par_typ_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_W-1:0]     shift_reg;
    logic                  par_armed;

    logic                  start_det;
    logic                  enable;
    logic                  sampled_bit;
    logic                  bit_done;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic                  sample_ready;

    assign start_det    = (state == IDLE || state == DONE) && !RX_IN;
    assign enable       = (state == START) || (state == DATA) ||
                          (state == PARITY) || (state == STOP);
    // First edge at which the registered majority vote of this bit is visible.
    assign sample_ready = (edge_cnt == (prescale_q >> 1) + PRESCALE_W'(3));

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk         (CLK),
        .rst_n       (RST),
        .rx_in       (RX_IN),
        .clear       (start_det),
        .enable      (enable),
        .prescale    (prescale_q),
        .sampled_bit (sampled_bit),
        .bit_done    (bit_done),
        .edge_cnt    (edge_cnt)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (!RX_IN) next_state = START;
            START: begin
                // A high start-bit vote is a glitch; abandon before the bit ends.
                if (sample_ready && sampled_bit) next_state = IDLE;
                else if (bit_done)               next_state = DATA;
            end
            DATA:   if (bit_done && bit_cnt == LAST_BIT)
                        next_state = par_en_q ? PARITY : STOP;
            PARITY: if (bit_done) next_state = STOP;
            STOP:   if (bit_done) next_state = DONE;
            DONE:   next_state = RX_IN ? IDLE : START;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are registered on the STOP->DONE transition so they are high
    // exactly during the DONE cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            prescale_q <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_armed  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (start_det) begin
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                prescale_q <= Prescale;
                bit_cnt    <= '0;
                par_armed  <= 1'b0;
            end

            case (state)
                DATA: if (bit_done) begin
                    shift_reg <= {sampled_bit, shift_reg[DATA_W-1:1]};
                    bit_cnt   <= bit_cnt + BCW'(1);
                end
                PARITY: if (bit_done)
                    par_armed <= sampled_bit != ((^shift_reg) ^ par_typ_q);
                STOP: if (bit_done) begin
                    STP_ERR <= !sampled_bit;
                    PAR_ERR <= par_armed;
                    if (sampled_bit && !par_armed) begin
                        DATA_VALID <= 1'b1;
                        P_DATA     <= shift_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    uart_rx #(
        .DATA_W     (8),
        .PRESCALE_W (6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_bad    = 0;

    int         cyc = 0;
    int         n_valid = 0;
    int         n_perr = 0;
    int         n_serr = 0;
    int         last_valid_cyc = 0;
    logic [7:0] vlog [8];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST) begin
            if (DATA_VALID) begin
                vlog[n_valid % 8] <= P_DATA;
                n_valid           <= n_valid + 1;
                last_valid_cyc    <= cyc;
            end
            if (PAR_ERR) n_perr <= n_perr + 1;
            if (STP_ERR) n_serr <= n_serr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input int ps, input logic pe, input logic pt,
                              input logic [7:0] d, input logic pbit, input logic stop);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        Prescale = 6'(ps);
        send_bit(1'b0, ps);
        for (int i = 0; i < 8; i++) send_bit(d[i], ps);
        if (pe) send_bit(pbit, ps);
        send_bit(stop, ps);
    endtask

    int v0, p0, s0, t0;

    task automatic snap();
        v0 = n_valid;
        p0 = n_perr;
        s0 = n_serr;
    endtask

    initial begin
        RST      = 1'b0;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = 6'd8;
        repeat (3) @(negedge CLK);
        check("reset p_data", 32'(P_DATA), 32'h00);
        check("reset valid", 32'(DATA_VALID), 0);
        check("reset par_err", 32'(PAR_ERR), 0);
        check("reset stp_err", 32'(STP_ERR), 0);
        RST = 1'b1;
        send_bit(1'b1, 10);

        // Prescale 8, no parity, 0xA5
        snap();
        t0 = cyc;
        send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
        send_bit(1'b1, 6);
        check("a5 valid count", 32'(n_valid - v0), 1);
        check("a5 p_data", 32'(P_DATA), 32'hA5);
        check("a5 par_err", 32'(n_perr - p0), 0);
        check("a5 stp_err", 32'(n_serr - s0), 0);
        check("a5 latency", 32'(last_valid_cyc - t0 >= 76 && last_valid_cyc - t0 <= 84), 1);

        // Prescale 16, even parity, 0x3C has four ones -> parity bit 0
        snap();
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1);
        send_bit(1'b1, 10);
        check("3c valid count", 32'(n_valid - v0), 1);
        check("3c p_data", 32'(P_DATA), 32'h3C);
        check("3c par_err", 32'(n_perr - p0), 0);

        // Same byte with wrong parity bit
        snap();
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1);
        send_bit(1'b1, 10);
        check("3c bad par valid", 32'(n_valid - v0), 0);
        check("3c bad par err", 32'(n_perr - p0), 1);
        check("3c bad par stp", 32'(n_serr - s0), 0);
        check("3c bad par hold", 32'(P_DATA), 32'h3C);

        // Prescale 32, 0x81 with stop bit low
        snap();
        send_frame(32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0);
        send_bit(1'b1, 40);
        check("81 stp_err", 32'(n_serr - s0), 1);
        check("81 par_err", 32'(n_perr - p0), 0);
        check("81 valid", 32'(n_valid - v0), 0);
        check("81 hold", 32'(P_DATA), 32'h3C);

        // Glitch: 3 low cycles at Prescale 16
        snap();
        Prescale = 6'd16;
        PAR_EN   = 1'b0;
        send_bit(1'b0, 3);
        send_bit(1'b1, 40);
        check("glitch valid", 32'(n_valid - v0), 0);
        check("glitch par", 32'(n_perr - p0), 0);
        check("glitch stp", 32'(n_serr - s0), 0);
        snap();
        send_frame(16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1);
        send_bit(1'b1, 10);
        check("55 valid", 32'(n_valid - v0), 1);
        check("55 p_data", 32'(P_DATA), 32'h55);

        // Back-to-back 0x01, 0xFE, then reset inside 0x77
        snap();
        send_frame(8, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1);
        send_frame(8, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b1, 8);
        send_bit(1'b1, 4);
        check("b2b valid count", 32'(n_valid - v0), 2);
        check("b2b first", 32'(vlog[v0 % 8]), 32'h01);
        check("b2b second", 32'(vlog[(v0 + 1) % 8]), 32'hFE);
        check("b2b errors", 32'(n_perr - p0 + n_serr - s0), 0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("midreset p_data", 32'(P_DATA), 32'h00);
        check("midreset valid", 32'(DATA_VALID), 0);
        check("midreset par_err", 32'(PAR_ERR), 0);
        check("midreset stp_err", 32'(STP_ERR), 0);
        RST = 1'b1;
        send_bit(1'b1, 120);
        check("no 77 strobe", 32'(n_valid - v0), 2);
        check("no 77 errors", 32'(n_perr - p0 + n_serr - s0), 0);

        // Receiver works again after reset
        snap();
        send_frame(8, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1);
        send_bit(1'b1, 10);
        check("77 valid", 32'(n_valid - v0), 1);
        check("77 p_data", 32'(P_DATA), 32'h77);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
